qerv_bufreg_w: RTL and testbench
================================

Name: qerv_bufreg_w

Overview:
- Parametrised buffer register for the bit/nibble-serial qerv datapath; supports BITS_PER_CYCLE of 1, 2, 4 or 8.
- Serially accumulates rs1+imm into a 32-bit register that drives the data-bus address and the extension rs1.
- Acts as the serial shift source for shift instructions, with sub-word shift residue carried between beats.
- New over the previous generation: asynchronous active-low reset on all state, W=2/8 support, and a beat counter that flags when the address is complete.

Parameters:
- MDU, 1'b0: when 1, i_mdu_op forces o_lsb to 2'b00.
- BITS_PER_CYCLE (W), 1: bits processed per i_en beat; legal values are 1, 2, 4, 8. Any other value is an elaboration error.
- LB, $clog2(W): width index for the shift-amount field.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cnt0  in  1  first beat of the 32-bit word
- i_cnt1  in  1  second beat (used only when W=1)
- i_en  in  1  beat enable; all state advances only when high
- i_init  in  1  1 = accumulate rs1+imm; 0 = shift phase
- i_mdu_op  in  1  MDU instruction active
- i_rs1_en, i_imm_en, i_clr_lsb  in  1 each  operand gating
- i_shift_op, i_right_shift_op, i_sh_signed  in  1 each  shift control
- i_rs1, i_imm  in  W each  serial operands, LSB first
- i_shift_counter_lsb  in  LB+1  sub-word shift amount; bit LB is always 0
- o_q  out  W  serial output; 0 when i_en=0
- o_lsb  out  2  address bits [1:0]
- o_adr_valid  out  1  o_dbus_adr holds the complete sum
- o_dbus_adr  out  32  {data[31:2],2'b00}
- o_ext_rs1  out  32  data

Behaviour:
- Reset (async, i_rst_n=0): data, c_r, residue, lsb, beat counter and o_adr_valid all go to 0 immediately. Consequently o_dbus_adr=0, o_lsb=0 and o_q=0.
- Adder (combinational, W+1 bits):
  - a = i_rs1_en ? i_rs1 : 0.
  - b = i_imm_en ? i_imm : 0, with b[0] forced to 0 when i_cnt0 & i_clr_lsb.
  - {c,q} = a + b + c_r.
  - c_r <= c & i_en, so carry is cleared on any idle cycle.
- Data register, on i_en: data <= {fill, data[31:W]}, where fill = i_init ? q : (i_sh_signed ? {W{data[31]}} : 0). A full word takes 32/W beats.
- Shift amount sa:
  - i_shift_op=0: sa = 0.
  - Left shift: sa = i_shift_counter_lsb.
  - Right shift: sa = (i_shift_counter_lsb==0) ? 0 : W - i_shift_counter_lsb.
  - For W=1, sa is always 0.
- Residue register (W bits):
  - On i_en: residue <= upper W bits of ({W'b0,data[W-1:0]} << sa).
  - Otherwise, when i_cnt0: residue <= 0.
  - i_en takes priority over the i_cnt0 clear.
- Output: o_q = i_en ? (lower W bits of (data[W-1:0] << sa)) | residue : 0.
- lsb capture:
  - W=1: lsb <= {i_init ? q : data[2], lsb[1]}, enabled when i_init ? (i_cnt0|i_cnt1) : i_en.
  - W>=2: lsb <= q[1:0] when i_en & i_cnt0.
- o_lsb = (MDU & i_mdu_op) ? 2'b00 : lsb.
- Beat counter (clog2(32/W) bits; 1 bit minimum when W=8 gives 4 beats, i.e. 2 bits):
  - Increments on i_en & i_init and wraps at 32/W-1.
  - Forced to 1 on i_en & i_init & i_cnt0, because the cnt0 beat counts as beat 0.
  - Holds when i_en=0 (stall).
- o_adr_valid (registered):
  - Set on the i_en & i_init beat where the counter equals 32/W-1.
  - Cleared on i_en & i_init & i_cnt0.
  - Holds otherwise, including through the shift phase.
  - If set and clear coincide (only possible when 32/W=1, which is illegal), clear wins.
- Stall: i_en=0 mid-word freezes data, lsb, residue and counter; c_r clears to 0. The controller must not stall inside a carry chain.
- Reset mid-word: all state zero; the next word starts clean from i_cnt0.

Decomposition:
- Package qerv_pkg:
  - legal W set check;
  - function beats(W) = 32/W;
  - shift-direction enum {SH_NONE, SH_LEFT, SH_RIGHT}.
- One sub-module, qerv_bufreg_shifter: computes sa, holds the residue register, produces o_q. It is parametrised by W and uses the same clock and async reset.

Test Plan:
- W=4, init, rs1=0x1000_0003, imm=0x0000_0011, clr_lsb=1, 8 beats from cnt0 -> o_dbus_adr=0x1000_0010, o_lsb=2'b11, o_adr_valid=1 one cycle after the 8th beat and 0 before it.
- W=4, rs1=0xFFFF_FFFF, imm=0x1, 8 beats -> data=0; final carry dropped; c_r=0 on the following idle cycle; stalling after beat 3 still yields the same result.
- W=4, data=0x8000_0000, i_init=0, i_sh_signed=1, 8 beats -> data=0xFFFF_FFFF; repeating with i_sh_signed=0 -> data=0.
- W=4, data=0x0000_000F, left shift, shift_counter_lsb=1 -> beat0 o_q=0xE, beat1 o_q=0x1, beats 2-7 o_q=0; o_q=0 whenever i_en=0.
- W=8 and W=1 repeats of the first scenario -> same address and o_lsb; o_adr_valid after 4 and 32 beats respectively.
- i_rst_n pulled low after 3 init beats -> all outputs 0 asynchronously; a new word completes normally. Separately, MDU=1 with i_mdu_op=1 -> o_lsb=2'b00.

Source files
------------

// File: rtl/qerv_pkg.sv
// qerv_pkg: shared types and width helpers
// for the qerv bit/nibble-serial datapath.
package qerv_pkg;

  typedef enum logic [1:0] {
    SH_NONE,
    SH_LEFT,
    SH_RIGHT
  } sh_dir_e;

  function automatic bit w_legal(input int w);
    return (w == 1) || (w == 2) ||
           (w == 4) || (w == 8);
  endfunction

  function automatic int beats(input int w);
    return 32 / w;
  endfunction

  // beat counter needs at least one bit
  function automatic int cnt_bits(input int w);
    return (32 / w > 2) ? $clog2(32 / w) : 1;
  endfunction

endpackage

// File: rtl/qerv_bufreg_w_if.sv
// qerv_bufreg_w_if: control, operand and bus
// bundle between the serial controller and bufreg.
interface qerv_bufreg_w_if #(
  parameter int W  = 1,
  parameter int LB = $clog2(W)
);
  logic          cnt0;
  logic          cnt1;
  logic          en;
  logic          init;
  logic          mdu_op;
  logic          rs1_en;
  logic          imm_en;
  logic          clr_lsb;
  logic          shift_op;
  logic          right_shift_op;
  logic          sh_signed;
  logic [W-1:0]  rs1;
  logic [W-1:0]  imm;
  logic [LB:0]   shift_counter_lsb;
  logic [W-1:0]  q;
  logic [1:0]    lsb;
  logic          adr_valid;
  logic [31:0]   dbus_adr;
  logic [31:0]   ext_rs1;

  modport master (
    output cnt0, cnt1, en, init, mdu_op,
    output rs1_en, imm_en, clr_lsb,
    output shift_op, right_shift_op, sh_signed,
    output rs1, imm, shift_counter_lsb,
    input  q, lsb, adr_valid, dbus_adr, ext_rs1
  );

  modport slave (
    input  cnt0, cnt1, en, init, mdu_op,
    input  rs1_en, imm_en, clr_lsb,
    input  shift_op, right_shift_op, sh_signed,
    input  rs1, imm, shift_counter_lsb,
    output q, lsb, adr_valid, dbus_adr, ext_rs1
  );
endinterface

// File: rtl/qerv_bufreg_shifter.sv
// qerv_bufreg_shifter: sub-word shift amount,
// residue carry between beats and serial output.
module qerv_bufreg_shifter
  import qerv_pkg::*;
#(
  parameter int W  = 1,
  parameter int LB = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          cnt0_i,
  input  logic          shift_op_i,
  input  logic          right_shift_op_i,
  input  logic [LB:0]   scl_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  q_o
);

  localparam logic [LB:0] WV = (LB+1)'(W);

  sh_dir_e          dir;
  logic [LB:0]      sa;
  logic [2*W-1:0]   shifted;
  logic [W-1:0]     res_q;
  logic [W-1:0]     res_d;

  always_comb begin
    dir = SH_NONE;
    if (shift_op_i)
      dir = right_shift_op_i ? SH_RIGHT : SH_LEFT;
  end

  always_comb begin
    sa = '0;
    unique case (1'b1)
      (dir == SH_LEFT):  sa = scl_i;
      (dir == SH_RIGHT):
        sa = (scl_i == '0) ? '0 : WV - scl_i;
      default:           sa = '0;
    endcase
    if (W == 1) sa = '0;
  end

  assign shifted = {{W{1'b0}}, data_i} << sa;

  // bits pushed past the beat wait for the next one
  always_comb begin
    res_d = res_q;
    if (en_i)        res_d = shifted[2*W-1:W];
    else if (cnt0_i) res_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign q_o = en_i ? (shifted[W-1:0] | res_q) : '0;

endmodule

// File: rtl/qerv_bufreg_w.sv
// qerv_bufreg_w: serial rs1+imm accumulator, address
// source and shift source for the qerv datapath.
module qerv_bufreg_w
  import qerv_pkg::*;
#(
  parameter logic MDU            = 1'b0,
  parameter int   BITS_PER_CYCLE = 1,
  parameter int   LB = $clog2(BITS_PER_CYCLE)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cnt0,
  input  logic                      i_cnt1,
  input  logic                      i_en,
  input  logic                      i_init,
  input  logic                      i_mdu_op,
  input  logic                      i_rs1_en,
  input  logic                      i_imm_en,
  input  logic                      i_clr_lsb,
  input  logic                      i_shift_op,
  input  logic                      i_right_shift_op,
  input  logic                      i_sh_signed,
  input  logic [BITS_PER_CYCLE-1:0] i_rs1,
  input  logic [BITS_PER_CYCLE-1:0] i_imm,
  input  logic [LB:0]               i_shift_counter_lsb,
  output logic [BITS_PER_CYCLE-1:0] o_q,
  output logic [1:0]                o_lsb,
  output logic                      o_adr_valid,
  output logic [31:0]               o_dbus_adr,
  output logic [31:0]               o_ext_rs1
);

  localparam int W  = BITS_PER_CYCLE;
  localparam int CB = cnt_bits(W);
  localparam logic [CB-1:0] LAST = CB'(beats(W) - 1);

  if (!w_legal(W)) begin : g_bad_w
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  q;
  logic          c;
  logic          c_r_q;
  logic [W-1:0]  fill;
  logic [31:0]   data_q;
  logic [31:0]   data_d;
  logic [1:0]    lsb_q;
  logic [CB-1:0] cnt_q;
  logic [CB-1:0] cnt_d;
  logic          adr_valid_q;
  logic          adr_valid_d;

  always_comb begin
    a = i_rs1_en ? i_rs1 : '0;
    b = i_imm_en ? i_imm : '0;
    if (i_cnt0 & i_clr_lsb) b[0] = 1'b0;
  end

  assign {c, q} = {1'b0, a} + {1'b0, b} +
                  {{W{1'b0}}, c_r_q};

  always_comb begin
    fill = '0;
    if (i_init)           fill = q;
    else if (i_sh_signed) fill = {W{data_q[31]}};
  end

  assign data_d = i_en ? {fill, data_q[31:W]} : data_q;

  // the cnt0 beat is beat 0, so the counter restarts at 1
  always_comb begin
    cnt_d       = cnt_q;
    adr_valid_d = adr_valid_q;
    if (i_en & i_init) begin
      if (i_cnt0) begin
        cnt_d       = CB'(1);
        adr_valid_d = 1'b0;
      end else begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CB'(1);
        if (cnt_q == LAST) adr_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_r_q       <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      adr_valid_q <= 1'b0;
    end else begin
      c_r_q       <= c & i_en;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      adr_valid_q <= adr_valid_d;
    end
  end

  if (W == 1) begin : g_lsb1
    logic lsb_en;
    logic lsb_in;
    assign lsb_en = i_init ? (i_cnt0 | i_cnt1) : i_en;
    assign lsb_in = i_init ? q[0] : data_q[2];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    lsb_q <= '0;
      else if (lsb_en) lsb_q <= {lsb_in, lsb_q[1]};
    end
  end else begin : g_lsbn
    logic unused_cnt1;
    assign unused_cnt1 = i_cnt1;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)             lsb_q <= '0;
      else if (i_en & i_cnt0) lsb_q <= q[1:0];
    end
  end

  qerv_bufreg_shifter #(
    .W  (W),
    .LB (LB)
  ) u_shifter (
    .clk              (i_clk),
    .rst_n            (i_rst_n),
    .en_i             (i_en),
    .cnt0_i           (i_cnt0),
    .shift_op_i       (i_shift_op),
    .right_shift_op_i (i_right_shift_op),
    .scl_i            (i_shift_counter_lsb),
    .data_i           (data_q[W-1:0]),
    .q_o              (o_q)
  );

  assign o_lsb       = (MDU & i_mdu_op) ? 2'b00 : lsb_q;
  assign o_adr_valid = adr_valid_q;
  assign o_dbus_adr  = {data_q[31:2], 2'b00};
  assign o_ext_rs1   = data_q;

endmodule

// File: tb/tb_qerv_bufreg_w.sv
// tb_qerv_bufreg_w: directed checks of qerv_bufreg_w
// at W=4 (main), W=8 with MDU, and W=1.
module tb_qerv_bufreg_w;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  qerv_bufreg_w_if #(.W(4)) b4();
  qerv_bufreg_w_if #(.W(8)) b8();
  qerv_bufreg_w_if #(.W(1)) b1();

  qerv_bufreg_w #(.MDU(1'b0), .BITS_PER_CYCLE(4)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cnt0(b4.cnt0), .i_cnt1(b4.cnt1),
    .i_en(b4.en), .i_init(b4.init),
    .i_mdu_op(b4.mdu_op), .i_rs1_en(b4.rs1_en),
    .i_imm_en(b4.imm_en), .i_clr_lsb(b4.clr_lsb),
    .i_shift_op(b4.shift_op),
    .i_right_shift_op(b4.right_shift_op),
    .i_sh_signed(b4.sh_signed),
    .i_rs1(b4.rs1), .i_imm(b4.imm),
    .i_shift_counter_lsb(b4.shift_counter_lsb),
    .o_q(b4.q), .o_lsb(b4.lsb),
    .o_adr_valid(b4.adr_valid),
    .o_dbus_adr(b4.dbus_adr), .o_ext_rs1(b4.ext_rs1)
  );

  qerv_bufreg_w #(.MDU(1'b1), .BITS_PER_CYCLE(8)) u_w8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cnt0(b8.cnt0), .i_cnt1(b8.cnt1),
    .i_en(b8.en), .i_init(b8.init),
    .i_mdu_op(b8.mdu_op), .i_rs1_en(b8.rs1_en),
    .i_imm_en(b8.imm_en), .i_clr_lsb(b8.clr_lsb),
    .i_shift_op(b8.shift_op),
    .i_right_shift_op(b8.right_shift_op),
    .i_sh_signed(b8.sh_signed),
    .i_rs1(b8.rs1), .i_imm(b8.imm),
    .i_shift_counter_lsb(b8.shift_counter_lsb),
    .o_q(b8.q), .o_lsb(b8.lsb),
    .o_adr_valid(b8.adr_valid),
    .o_dbus_adr(b8.dbus_adr), .o_ext_rs1(b8.ext_rs1)
  );

  qerv_bufreg_w #(.MDU(1'b0), .BITS_PER_CYCLE(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cnt0(b1.cnt0), .i_cnt1(b1.cnt1),
    .i_en(b1.en), .i_init(b1.init),
    .i_mdu_op(b1.mdu_op), .i_rs1_en(b1.rs1_en),
    .i_imm_en(b1.imm_en), .i_clr_lsb(b1.clr_lsb),
    .i_shift_op(b1.shift_op),
    .i_right_shift_op(b1.right_shift_op),
    .i_sh_signed(b1.sh_signed),
    .i_rs1(b1.rs1), .i_imm(b1.imm),
    .i_shift_counter_lsb(b1.shift_counter_lsb),
    .o_q(b1.q), .o_lsb(b1.lsb),
    .o_adr_valid(b1.adr_valid),
    .o_dbus_adr(b1.dbus_adr), .o_ext_rs1(b1.ext_rs1)
  );

  task automatic zero_inputs();
    b4.cnt0 = 0; b4.cnt1 = 0; b4.en = 0; b4.init = 0;
    b4.mdu_op = 0; b4.rs1_en = 0; b4.imm_en = 0;
    b4.clr_lsb = 0; b4.shift_op = 0;
    b4.right_shift_op = 0; b4.sh_signed = 0;
    b4.rs1 = '0; b4.imm = '0; b4.shift_counter_lsb = '0;
    b8.cnt0 = 0; b8.cnt1 = 0; b8.en = 0; b8.init = 0;
    b8.mdu_op = 0; b8.rs1_en = 0; b8.imm_en = 0;
    b8.clr_lsb = 0; b8.shift_op = 0;
    b8.right_shift_op = 0; b8.sh_signed = 0;
    b8.rs1 = '0; b8.imm = '0; b8.shift_counter_lsb = '0;
    b1.cnt0 = 0; b1.cnt1 = 0; b1.en = 0; b1.init = 0;
    b1.mdu_op = 0; b1.rs1_en = 0; b1.imm_en = 0;
    b1.clr_lsb = 0; b1.shift_op = 0;
    b1.right_shift_op = 0; b1.sh_signed = 0;
    b1.rs1 = '0; b1.imm = '0; b1.shift_counter_lsb = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      b4.en = 0; b4.cnt0 = 0;
      b8.en = 0; b8.cnt0 = 0;
      b1.en = 0; b1.cnt0 = 0; b1.cnt1 = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic w4_setup(input logic clr);
    b4.init = 1; b4.rs1_en = 1; b4.imm_en = 1;
    b4.clr_lsb = clr; b4.shift_op = 0;
    b4.right_shift_op = 0; b4.sh_signed = 0;
  endtask

  task automatic w4_beats(input logic [31:0] rs1,
                          input logic [31:0] imm,
                          input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      b4.cnt0 = (k == 0);
      b4.rs1  = rs1[4*k +: 4];
      b4.imm  = imm[4*k +: 4];
      b4.en   = 1;
      @(posedge clk); #1;
    end
    b4.en = 0; b4.cnt0 = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (b4.dbus_adr !== 32'h0 || b4.lsb !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_w4: adr=%h lsb=%b want 0",
               b4.dbus_adr, b4.lsb);
    end
    n_chk++;
    if (b4.adr_valid !== 1'b0 || b4.q !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_w4_vq: valid=%b q=%h want 0",
               b4.adr_valid, b4.q);
    end
    n_chk++;
    if (b8.ext_rs1 !== 32'h0 || b1.ext_rs1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_w8w1: %h %h want 0",
               b8.ext_rs1, b1.ext_rs1);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addr_w4();
    w4_setup(1'b1);
    w4_beats(32'h1000_0003, 32'h0000_0011, 0, 6);
    n_chk++;
    if (b4.adr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_valid_early: got %b want 0",
               b4.adr_valid);
    end
    w4_beats(32'h1000_0003, 32'h0000_0011, 7, 7);
    n_chk++;
    if (b4.adr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_valid: got %b want 1",
               b4.adr_valid);
    end
    n_chk++;
    if (b4.dbus_adr !== 32'h1000_0010) begin
      n_fail++;
      $display("FAIL addr_dbus: got %h want 10000010",
               b4.dbus_adr);
    end
    n_chk++;
    if (b4.lsb !== 2'b11 || b4.ext_rs1 !== 32'h1000_0013) begin
      n_fail++;
      $display("FAIL addr_lsb: lsb=%b rs1=%h want 11 10000013",
               b4.lsb, b4.ext_rs1);
    end
    idle(1);
  endtask

  task automatic test_carry_w4();
    w4_setup(1'b0);
    w4_beats(32'hFFFF_FFFF, 32'h0000_0001, 0, 7);
    n_chk++;
    if (b4.ext_rs1 !== 32'h0) begin
      n_fail++;
      $display("FAIL carry_sum: got %h want 0", b4.ext_rs1);
    end
    idle(1);
    w4_beats(32'h0, 32'h0, 0, 7);
    n_chk++;
    if (b4.ext_rs1 !== 32'h0) begin
      n_fail++;
      $display("FAIL carry_leak: got %h want 0", b4.ext_rs1);
    end
    idle(1);
  endtask

  task automatic test_stall_w4();
    w4_setup(1'b1);
    w4_beats(32'h1000_0003, 32'h0000_0011, 0, 3);
    idle(2);
    n_chk++;
    if (b4.ext_rs1 !== 32'h0013_0000 ||
        b4.adr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: rs1=%h v=%b want 00130000 0",
               b4.ext_rs1, b4.adr_valid);
    end
    w4_beats(32'h1000_0003, 32'h0000_0011, 4, 7);
    n_chk++;
    if (b4.ext_rs1 !== 32'h1000_0013 ||
        b4.adr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_sum: rs1=%h v=%b want 10000013 1",
               b4.ext_rs1, b4.adr_valid);
    end
    idle(1);
  endtask

  task automatic test_sext_w4();
    w4_setup(1'b0);
    w4_beats(32'h8000_0000, 32'h0, 0, 7);
    b4.init = 0; b4.rs1_en = 0; b4.imm_en = 0;
    b4.sh_signed = 1;
    w4_beats(32'h0, 32'h0, 0, 7);
    n_chk++;
    if (b4.ext_rs1 !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sext_signed: got %h want ffffffff",
               b4.ext_rs1);
    end
    n_chk++;
    if (b4.adr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sext_valid_hold: got %b want 1",
               b4.adr_valid);
    end
    idle(1);
    w4_setup(1'b0);
    w4_beats(32'h8000_0000, 32'h0, 0, 7);
    b4.init = 0; b4.rs1_en = 0; b4.imm_en = 0;
    b4.sh_signed = 0;
    w4_beats(32'h0, 32'h0, 0, 7);
    n_chk++;
    if (b4.ext_rs1 !== 32'h0) begin
      n_fail++;
      $display("FAIL sext_unsigned: got %h want 0",
               b4.ext_rs1);
    end
    idle(1);
  endtask

  task automatic test_shift_w4();
    logic [3:0] acc;
    w4_setup(1'b0);
    w4_beats(32'h0000_000F, 32'h0, 0, 7);
    idle(1);
    b4.init = 0; b4.rs1_en = 0; b4.imm_en = 0;
    b4.shift_op = 1; b4.right_shift_op = 0;
    b4.shift_counter_lsb = 3'd1;
    b4.cnt0 = 1; b4.en = 1;
    @(negedge clk);
    n_chk++;
    if (b4.q !== 4'hE) begin
      n_fail++;
      $display("FAIL shl_beat0: got %h want e", b4.q);
    end
    @(posedge clk); #1;
    b4.cnt0 = 0; b4.en = 0;
    @(negedge clk);
    n_chk++;
    if (b4.q !== 4'h0) begin
      n_fail++;
      $display("FAIL shl_idle_q: got %h want 0", b4.q);
    end
    @(posedge clk); #1;
    b4.en = 1;
    @(negedge clk);
    n_chk++;
    if (b4.q !== 4'h1) begin
      n_fail++;
      $display("FAIL shl_beat1: got %h want 1", b4.q);
    end
    @(posedge clk); #1;
    acc = '0;
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      acc = acc | b4.q;
      @(posedge clk); #1;
    end
    b4.en = 0;
    n_chk++;
    if (acc !== 4'h0) begin
      n_fail++;
      $display("FAIL shl_tail: or=%h want 0", acc);
    end
    idle(1);
    w4_setup(1'b0);
    w4_beats(32'h0000_000F, 32'h0, 0, 7);
    idle(1);
    b4.init = 0; b4.rs1_en = 0; b4.imm_en = 0;
    b4.shift_op = 1; b4.right_shift_op = 1;
    b4.shift_counter_lsb = 3'd1;
    b4.cnt0 = 1; b4.en = 1;
    @(negedge clk);
    n_chk++;
    if (b4.q !== 4'h8) begin
      n_fail++;
      $display("FAIL shr_beat0: got %h want 8", b4.q);
    end
    @(posedge clk); #1;
    b4.cnt0 = 0;
    @(negedge clk);
    n_chk++;
    if (b4.q !== 4'h7) begin
      n_fail++;
      $display("FAIL shr_beat1: got %h want 7", b4.q);
    end
    @(posedge clk); #1;
    b4.en = 0; b4.shift_op = 0; b4.right_shift_op = 0;
    idle(1);
  endtask

  task automatic test_w8();
    logic [31:0] rs1;
    logic [31:0] imm;
    rs1 = 32'h1000_0003;
    imm = 32'h0000_0011;
    b8.init = 1; b8.rs1_en = 1; b8.imm_en = 1;
    b8.clr_lsb = 1;
    for (int k = 0; k < 4; k++) begin
      b8.cnt0 = (k == 0);
      b8.rs1 = rs1[8*k +: 8];
      b8.imm = imm[8*k +: 8];
      b8.en = 1;
      if (k == 3) begin
        n_chk++;
        if (b8.adr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL w8_valid_early: got %b want 0",
                   b8.adr_valid);
        end
      end
      @(posedge clk); #1;
    end
    b8.en = 0; b8.cnt0 = 0;
    n_chk++;
    if (b8.adr_valid !== 1'b1 ||
        b8.dbus_adr !== 32'h1000_0010) begin
      n_fail++;
      $display("FAIL w8_addr: v=%b adr=%h want 1 10000010",
               b8.adr_valid, b8.dbus_adr);
    end
    n_chk++;
    if (b8.lsb !== 2'b11) begin
      n_fail++;
      $display("FAIL w8_lsb: got %b want 11", b8.lsb);
    end
    b8.mdu_op = 1; #1;
    n_chk++;
    if (b8.lsb !== 2'b00) begin
      n_fail++;
      $display("FAIL w8_mdu_lsb: got %b want 00", b8.lsb);
    end
    b8.mdu_op = 0;
    idle(1);
  endtask

  task automatic test_w1();
    logic [31:0] rs1;
    logic [31:0] imm;
    rs1 = 32'h1000_0003;
    imm = 32'h0000_0011;
    b1.init = 1; b1.rs1_en = 1; b1.imm_en = 1;
    b1.clr_lsb = 1;
    for (int k = 0; k < 32; k++) begin
      b1.cnt0 = (k == 0);
      b1.cnt1 = (k == 1);
      b1.rs1 = rs1[k];
      b1.imm = imm[k];
      b1.en = 1;
      if (k == 31) begin
        n_chk++;
        if (b1.adr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL w1_valid_early: got %b want 0",
                   b1.adr_valid);
        end
      end
      @(posedge clk); #1;
    end
    b1.en = 0; b1.cnt0 = 0; b1.cnt1 = 0;
    n_chk++;
    if (b1.adr_valid !== 1'b1 ||
        b1.dbus_adr !== 32'h1000_0010) begin
      n_fail++;
      $display("FAIL w1_addr: v=%b adr=%h want 1 10000010",
               b1.adr_valid, b1.dbus_adr);
    end
    n_chk++;
    if (b1.lsb !== 2'b11) begin
      n_fail++;
      $display("FAIL w1_lsb: got %b want 11", b1.lsb);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    w4_setup(1'b1);
    w4_beats(32'h1000_0003, 32'h0000_0011, 0, 2);
    n_chk++;
    if (b4.ext_rs1 !== 32'h0130_0000 || b4.lsb !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_pre: rs1=%h lsb=%b want 01300000 11",
               b4.ext_rs1, b4.lsb);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (b4.ext_rs1 !== 32'h0 || b4.dbus_adr !== 32'h0 ||
        b4.lsb !== 2'b00 || b4.q !== 4'h0) begin
      n_fail++;
      $display("FAIL rstmid_w4: rs1=%h adr=%h lsb=%b q=%h",
               b4.ext_rs1, b4.dbus_adr, b4.lsb, b4.q);
    end
    n_chk++;
    if (b8.adr_valid !== 1'b0 || b1.adr_valid !== 1'b0 ||
        b8.lsb !== 2'b00 || b1.dbus_adr !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: v8=%b v1=%b l8=%b a1=%h",
               b8.adr_valid, b1.adr_valid, b8.lsb,
               b1.dbus_adr);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    w4_setup(1'b1);
    w4_beats(32'h1000_0003, 32'h0000_0011, 0, 7);
    n_chk++;
    if (b4.ext_rs1 !== 32'h1000_0013 ||
        b4.adr_valid !== 1'b1 || b4.lsb !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_post: rs1=%h v=%b lsb=%b",
               b4.ext_rs1, b4.adr_valid, b4.lsb);
    end
    idle(1);
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_addr_w4();
    test_carry_w4();
    test_stall_w4();
    test_sext_w4();
    test_shift_w4();
    test_w8();
    test_w1();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
